// File: rtl/system_pkg.sv
// Shared bus widths and AHB-Lite encodings for the core-side bus blocks.
// Also holds the byte-lane decode used by SRAM responders.
package system_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BYTE = 3'b000,
        HALF = 3'b001,
        WORD = 3'b010
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Lane enables for an aligned access; oversize/misaligned cases are rejected before use.
    function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [2:0] sz);
        case (sz)
            BYTE:    byte_en = 4'b0001 << a;
            HALF:    byte_en = 4'b0011 << {a[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_sp_be.sv
// Single-port SRAM with per-byte write enables and a registered 1-cycle read port.
// The array and q are not reset.
module sram_sp_be
    import system_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // q only moves on reads so it stays stable through any read wait states.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder in front of a single-port SRAM: single transfers,
// programmable data-phase wait states and a two-cycle ERROR response.
module ahbl_sram_slave
    import system_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    MEM_WORDS   = 4096,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rstn_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o
);

    localparam int                    IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);
    localparam logic [2:0]            WS        = 3'(WAIT_STATES);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_ERR1     = 3'd4;
    localparam logic [2:0] ST_ERR2     = 3'd5;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [3:0]       be;
    } dph_t;

    logic [2:0]            state_q, state_d;
    logic [2:0]            wcnt_q, wcnt_d;
    dph_t                  dph_q, dph_d;
    logic [ADDR_WIDTH-1:0] off;
    logic                  accept, acc_err, done, fin;
    logic                  sram_en, sram_we;
    logic [DATA_WIDTH-1:0] sram_q;
    logic                  unused_ok;

    assign unused_ok = ^{htrans_i[0], hburst_i, hprot_i, hmastlock_i, off[1:0]};

    assign accept  = hsel_i & htrans_i[1] & hready_i;
    assign off     = haddr_i - BASE_ADDR;
    // Addresses below BASE_ADDR wrap to huge offsets and fail the range check too.
    assign acc_err = (hsize_i > WORD)
                   | ((hsize_i == HALF) & haddr_i[0])
                   | ((hsize_i == WORD) & (haddr_i[1:0] != 2'b00))
                   | (off >= MEM_BYTES);

    assign done = (wcnt_q == WS);
    assign fin  = (((state_q == ST_WR) || (state_q == ST_RD_DATA)) && done)
                || (state_q == ST_ERR2);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        dph_d       = dph_q;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        hrdata_o    = '0;
        case (state_q)
            ST_WR: begin
                hreadyout_o = done;
                if (done) begin
                    sram_en = 1'b1;
                    sram_we = 1'b1;
                    wcnt_d  = 3'd0;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_RD_ISSUE: begin
                hreadyout_o = 1'b0;
                sram_en     = 1'b1;
                state_d     = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                hreadyout_o = done;
                if (done) begin
                    hrdata_o = sram_q;
                    wcnt_d   = 3'd0;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_d     = ST_ERR2;
            end
            ST_ERR2: hresp_o = HRESP_ERROR;
            default: ;
        endcase
        if ((state_q == ST_IDLE) || fin) begin
            state_d = ST_IDLE;
            if (accept) begin
                state_d   = acc_err ? ST_ERR1 : (hwrite_i ? ST_WR : ST_RD_ISSUE);
                dph_d.idx = off[IDX_W+1:2];
                dph_d.be  = byte_en(haddr_i[1:0], hsize_i);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 3'd0;
            dph_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            dph_q   <= dph_d;
        end
    end

    // Reset in the same cycle as a final write beat must drop the write.
    sram_sp_be #(.DEPTH(MEM_WORDS), .AW(IDX_W)) u_sram (
        .clk   (sys_clk_i),
        .en    (sram_en & sys_rstn_i),
        .we    (sram_we),
        .be    (dph_q.be),
        .addr  (dph_q.idx),
        .wdata (hwdata_i),
        .q     (sram_q)
    );

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Bench for ahbl_sram_slave: two instances (0 and 2 wait states) on a shared bus,
// a vector table driven through a scoreboard queue, plus pipelined and reset sequences.
module tb_ahbl_sram_slave;
    import system_pkg::*;

    typedef struct {
        int          which;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn0, rstn2, hsel0, hsel2, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        rdy0, rdy2, resp0, resp2;
    logic [31:0] rd0, rd2;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vt[$];
    vec_t        sbq[$];

    always #5 clk = ~clk;

    ahbl_sram_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(4096), .WAIT_STATES(0)) dut0 (
        .sys_clk_i(clk), .sys_rstn_i(rstn0), .hsel_i(hsel0), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000),
        .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(rdy0),
        .hreadyout_o(rdy0), .hresp_o(resp0), .hrdata_o(rd0));

    ahbl_sram_slave #(.BASE_ADDR(32'h0), .MEM_WORDS(4096), .WAIT_STATES(2)) dut2 (
        .sys_clk_i(clk), .sys_rstn_i(rstn2), .hsel_i(hsel2), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000),
        .hprot_i(4'b0011), .hmastlock_i(1'b0), .hwdata_i(hwdata), .hready_i(rdy2),
        .hreadyout_o(rdy2), .hresp_o(resp2), .hrdata_o(rd2));

    function automatic vec_t mk(input int which, input logic wr, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int waits);
        vec_t v;
        v.which = which; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.waits = waits;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One non-pipelined transfer; returns final-cycle outputs and wait-cycle observations.
    task automatic xfer(input vec_t v, output logic [31:0] rdata, output logic resp,
                        output int waits, output logic resp_w, output logic rd_w);
        logic r;
        @(negedge clk);
        hsel0 = (v.which == 0); hsel2 = (v.which == 2);
        htrans = NONSEQ; haddr = v.addr; hwrite = v.wr; hsize = v.size;
        @(negedge clk);
        hsel0 = 1'b0; hsel2 = 1'b0; htrans = IDLE; hwdata = v.wdata;
        waits = 0; resp_w = 1'b0; rd_w = 1'b0;
        r = (v.which == 2) ? rdy2 : rdy0;
        while (!r && waits < 20) begin
            resp_w |= (v.which == 2) ? resp2 : resp0;
            rd_w   |= |((v.which == 2) ? rd2 : rd0);
            waits++;
            @(negedge clk);
            r = (v.which == 2) ? rdy2 : rdy0;
        end
        if (!r) begin
            n_vec++; n_bad++;
            $display("FAIL timeout: hreadyout stuck low at addr %h", v.addr);
        end
        rdata = (v.which == 2) ? rd2 : rd0;
        resp  = (v.which == 2) ? resp2 : resp0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        e;
        logic [31:0] rdata;
        logic        resp, resp_w, rd_w;
        int          waits;

        vt.push_back(mk(0, 1, 32'h10,   WORD,   32'hDEADBEEF, 32'h0,        0, 0));
        vt.push_back(mk(0, 0, 32'h10,   WORD,   32'h0,        32'hDEADBEEF, 0, 1));
        vt.push_back(mk(0, 1, 32'h13,   BYTE,   32'hAA000000, 32'h0,        0, 0));
        vt.push_back(mk(0, 0, 32'h10,   WORD,   32'h0,        32'hAAADBEEF, 0, 1));
        vt.push_back(mk(0, 1, 32'h12,   HALF,   32'h12340000, 32'h0,        0, 0));
        vt.push_back(mk(0, 0, 32'h10,   WORD,   32'h0,        32'h1234BEEF, 0, 1));
        vt.push_back(mk(0, 1, 32'h11,   HALF,   32'hFFFFFFFF, 32'h0,        1, 1));
        vt.push_back(mk(0, 1, 32'h4000, WORD,   32'hFFFFFFFF, 32'h0,        1, 1));
        vt.push_back(mk(0, 1, 32'h10,   3'b011, 32'hFFFFFFFF, 32'h0,        1, 1));
        vt.push_back(mk(0, 0, 32'h10,   WORD,   32'h0,        32'h1234BEEF, 0, 1));
        vt.push_back(mk(0, 0, 32'h12,   HALF,   32'h0,        32'h1234BEEF, 0, 1));
        vt.push_back(mk(0, 0, 32'h11,   WORD,   32'h0,        32'h0,        1, 1));
        vt.push_back(mk(0, 1, 32'h3FFC, WORD,   32'hCAFEF00D, 32'h0,        0, 0));
        vt.push_back(mk(0, 0, 32'h3FFC, WORD,   32'h0,        32'hCAFEF00D, 0, 1));
        vt.push_back(mk(0, 1, 32'h10,   BYTE,   32'h00000077, 32'h0,        0, 0));
        vt.push_back(mk(0, 0, 32'h10,   WORD,   32'h0,        32'h1234BE77, 0, 1));
        vt.push_back(mk(2, 1, 32'h40,   WORD,   32'h01020304, 32'h0,        0, 2));
        vt.push_back(mk(2, 0, 32'h40,   WORD,   32'h0,        32'h01020304, 0, 3));
        vt.push_back(mk(2, 0, 32'h41,   HALF,   32'h0,        32'h0,        1, 1));
        vt.push_back(mk(2, 1, 32'h42,   HALF,   32'hABCD0000, 32'h0,        0, 2));
        vt.push_back(mk(2, 0, 32'h40,   WORD,   32'h0,        32'hABCD0304, 0, 3));

        rstn0 = 1'b0; rstn2 = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0;
        htrans = IDLE; haddr = '0; hwrite = 1'b0; hsize = WORD; hwdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy0",  32'(rdy0),  32'h1);
        check("rst_resp0", 32'(resp0), 32'h0);
        check("rst_rd0",   rd0,        32'h0);
        check("rst_rdy2",  32'(rdy2),  32'h1);
        check("rst_resp2", 32'(resp2), 32'h0);
        check("rst_rd2",   rd2,        32'h0);
        rstn0 = 1'b1; rstn2 = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            sbq.push_back(vt[i]);
            xfer(vt[i], rdata, resp, waits, resp_w, rd_w);
            e = sbq.pop_front();
            check($sformatf("v%0d_waits", i), 32'(waits), 32'(e.waits));
            check($sformatf("v%0d_resp", i), 32'(resp), 32'(e.err));
            check($sformatf("v%0d_resp_wait", i), 32'(resp_w), 32'(e.err));
            check($sformatf("v%0d_rdata", i), rdata, e.rdata);
            check($sformatf("v%0d_rdata_wait", i), 32'(rd_w), 32'h0);
        end

        // Read accepted in the write's final data cycle.
        @(negedge clk);
        hsel0 = 1'b1; htrans = NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = WORD;
        @(negedge clk);
        check("b2b_wr_rdy", 32'(rdy0), 32'h1);
        hwdata = 32'h5A5A5A5A; hwrite = 1'b0;
        sbq.push_back(mk(0, 0, 32'h20, WORD, 32'h0, 32'h5A5A5A5A, 0, 1));
        @(negedge clk);
        hsel0 = 1'b0; htrans = IDLE;
        check("b2b_rd_issue_rdy", 32'(rdy0), 32'h0);
        @(negedge clk);
        e = sbq.pop_front();
        check("b2b_rd_rdy",   32'(rdy0),  32'h1);
        check("b2b_rd_resp",  32'(resp0), 32'(e.err));
        check("b2b_rd_rdata", rd0,        e.rdata);

        // Reset during the second write wait cycle drops the write.
        @(negedge clk);
        hsel2 = 1'b1; htrans = NONSEQ; haddr = 32'h40; hwrite = 1'b1; hsize = WORD;
        @(negedge clk);
        hsel2 = 1'b0; htrans = IDLE; hwdata = 32'hFFFFFFFF;
        check("rstmid_wait1", 32'(rdy2), 32'h0);
        @(negedge clk);
        check("rstmid_wait2", 32'(rdy2), 32'h0);
        rstn2 = 1'b0;
        @(negedge clk);
        check("rstmid_rdy",   32'(rdy2),  32'h1);
        check("rstmid_resp",  32'(resp2), 32'h0);
        check("rstmid_rdata", rd2,        32'h0);
        rstn2 = 1'b1;
        sbq.push_back(mk(2, 0, 32'h40, WORD, 32'h0, 32'hABCD0304, 0, 3));
        xfer(sbq[0], rdata, resp, waits, resp_w, rd_w);
        e = sbq.pop_front();
        check("rstmid_rd_waits", 32'(waits), 32'(e.waits));
        check("rstmid_rd_rdata", rdata,      e.rdata);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
